// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with a consumed-result counter.
// Optional zero/parity result flags are enabled by defining LOGIC_UNIT_PIPE_FLAGS_EN.
`timescale 1ns/1ps
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] op_count
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    ,
    output logic             zero,
    output logic             parity
`endif
);

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [2:0]       s1_op_q;
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_res_q;
    logic [CNT_W-1:0] op_count_q;
    logic [WIDTH-1:0] res_d;
    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic             consume;

    assign s2_adv  = !s2_valid_q || out_ready;
    assign s1_adv  = !s1_valid_q || s2_adv;
    // Held low during reset so nothing is accepted into a clearing pipeline.
    assign in_ready = !rst && s1_adv;
    assign accept   = in_valid && in_ready;
    assign consume  = s2_valid_q && out_ready;

    always_comb begin
        res_d = '0;
        case (s1_op_q)
            3'd0:    res_d = s1_a_q & s1_b_q;
            3'd1:    res_d = s1_a_q | s1_b_q;
            3'd2:    res_d = s1_a_q ^ s1_b_q;
            3'd3:    res_d = ~(s1_a_q ^ s1_b_q);
            3'd4:    res_d = ~(s1_a_q & s1_b_q);
            3'd5:    res_d = ~(s1_a_q | s1_b_q);
            3'd6:    res_d = ~s1_a_q;
            default: res_d = s1_a_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_a_q  <= inA;
                s1_b_q  <= inB;
                s1_op_q <= op;
            end
        end
    end

    // Bubbles advance valid only; the last result stays on the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_res_q <= res_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else if (consume) begin
            op_count_q <= op_count_q + CNT_W'(1);
        end
    end

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    logic zero_q;
    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
        end else if (s2_adv && s1_valid_q) begin
            zero_q   <= ~|res_d;
            parity_q <= ^res_d;
        end
    end

    assign zero   = zero_q;
    assign parity = parity_q;
`endif

    assign result    = s2_res_q;
    assign out_valid = s2_valid_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: vector table, backpressure, reset and counter-wrap
// sequences, and a random valid/ready run, all scored through an in-order queue.
`timescale 1ns/1ps
module tb_logic_unit_pipe;
    localparam int W  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [2:0]    op;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  result;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] op_count;
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    logic          zero;
    logic          parity;
`endif

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .inA       (in_a),
        .inB       (in_b),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_count  (op_count)
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
        ,
        .zero      (zero),
        .parity    (parity)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] exp;
    } vec_t;

    vec_t         tbl[14];
    int           n_vec = 0;
    int           n_err = 0;
    int           n_acc = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] exp_res;
    bit           stall_q = 1'b0;
    logic [W-1:0] stall_res;
    bit           done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] o);
        case (o)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return a ~^ b;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_hold", 64'(result), 64'(stall_res));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL spurious: result %0h emitted, nothing expected", result);
                    end else begin
                        e = sb.pop_front();
                        check("result", 64'(result), 64'(e));
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
                        check("zero", 64'(zero), 64'(~|e));
                        check("parity", 64'(parity), 64'(^e));
`endif
                    end
                end
                if (in_valid && in_ready) begin
                    sb.push_back(exp_res);
                    n_acc++;
                end
                stall_q   = out_valid && !out_ready;
                stall_res = result;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                        input logic [W-1:0] e);
        bit ok = 1'b0;
        in_a = a; in_b = b; op = o; exp_res = e; in_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
        check("rst_zero", 64'(zero), 64'd1);
        check("rst_parity", 64'(parity), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check("ready_after_rst", 64'(in_ready), 64'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            #3;
            if (sb.size() == 0 && !out_valid) break;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int a0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; op = '0; exp_res = '0; done = 1'b0;

        tbl[0]  = '{8'hF0, 8'h3C, 3'd0, 8'h30};
        tbl[1]  = '{8'hF0, 8'h3C, 3'd1, 8'hFC};
        tbl[2]  = '{8'hF0, 8'h3C, 3'd2, 8'hCC};
        tbl[3]  = '{8'hF0, 8'h3C, 3'd3, 8'h33};
        tbl[4]  = '{8'hF0, 8'h3C, 3'd4, 8'hCF};
        tbl[5]  = '{8'hF0, 8'h3C, 3'd5, 8'h03};
        tbl[6]  = '{8'hF0, 8'h3C, 3'd6, 8'h0F};
        tbl[7]  = '{8'hF0, 8'h3C, 3'd7, 8'hF0};
        tbl[8]  = '{8'hAA, 8'hAA, 3'd2, 8'h00};
        tbl[9]  = '{8'hAA, 8'hAA, 3'd1, 8'hAA};
        tbl[10] = '{8'h01, 8'hFF, 3'd7, 8'h01};
        tbl[11] = '{8'h5A, 8'h12, 3'd6, 8'hA5};
        tbl[12] = '{8'hFF, 8'h00, 3'd0, 8'h00};
        tbl[13] = '{8'h00, 8'h00, 3'd5, 8'hFF};

        do_reset();

        // Back-to-back ops 0..7: two-cycle latency, then one result per cycle.
        fork
            begin
                for (int i = 0; i < 8; i++) send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp);
            end
            begin
                @(negedge clk); check("lat_c0", 64'(out_valid), 64'd0);
                @(negedge clk); check("lat_c1", 64'(out_valid), 64'd0);
                repeat (8) begin
                    @(negedge clk); check("stream_valid", 64'(out_valid), 64'd1);
                end
                @(negedge clk); check("stream_end", 64'(out_valid), 64'd0);
                check("count_8", 64'(op_count), 64'd8);
            end
        join
        drain();

        for (int i = 8; i < 14; i++) send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp);
        drain();

        // Backpressure: only two ops fit while the output is stalled.
        out_ready = 1'b0;
        a0 = n_acc;
        fork
            begin
                for (int i = 8; i < 12; i++) send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp);
            end
            begin
                repeat (5) @(posedge clk);
                #3;
                check("bp_accepts", 64'(n_acc - a0), 64'd2);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_all_accepted", 64'(n_acc - a0), 64'd4);

        // Reset with two ops in flight: nothing from before may surface.
        out_ready = 1'b0;
        send(tbl[0].a, tbl[0].b, tbl[0].op, tbl[0].exp);
        send(tbl[1].a, tbl[1].b, tbl[1].op, tbl[1].exp);
        do_reset();
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk); check("no_stale", 64'(out_valid), 64'd0);
        end

        // Random valid gaps and output stalls.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [W-1:0] ra;
                    logic [W-1:0] rb;
                    logic [2:0]   ro;
                    int           gap;
                    gap = $urandom_range(0, 2);
                    repeat (gap) begin
                        @(posedge clk);
                        #1;
                    end
                    ra = W'($urandom);
                    rb = W'($urandom);
                    ro = 3'($urandom_range(0, 7));
                    send(ra, rb, ro, model(ra, rb, ro));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Counter wrap.
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            send(8'(i), 8'(~i), 3'(i), model(8'(i), 8'(~i), 3'(i)));
        end
        drain();
        check("count_ffff", 64'(op_count), 64'hFFFF);
        send(8'h3C, 8'hC3, 3'd1, 8'hFF);
        drain();
        check("count_wrap", 64'(op_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
